// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// Optional overflow output is enabled with the PIPE_ADDER_OVF_EN macro.
package pipe_adder_pkg;

  // Bits added per pipeline stage unless a user overrides SEG_W.
  localparam int SEG_W_DEFAULT = 4;

  // Number of pipeline stages needed to cover a width.
  function automatic int nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  // Control part of one stage record. The segment sum travels next to it
  // because its width depends on SEG_W.
  typedef struct packed {
    logic valid;
    logic carry;
  } seg_ctl_t;

endpackage

// File: rtl/adder_seg.sv
// One registered SEG_W-bit add stage: sum and carry out are captured when en is high.
// With PIPE_ADDER_OVF_EN defined it also registers the carry into its MSB.
module adder_seg
  import pipe_adder_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid,
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output seg_ctl_t         ctl,
  output logic [SEG_W-1:0] sum
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             msb_carry
`endif
);

  logic [SEG_W:0] total;

  // Segment add with one extra bit to hold the carry out.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
  end

  // Stage register: holds its contents when the pipeline is stalled.
  // NOTE: state is written with non-blocking assignments so all stages update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl <= '0;
      sum <= '0;
    end else if (en) begin
      ctl.valid <= valid;
      ctl.carry <= total[SEG_W];
      sum       <= total[SEG_W-1:0];
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit and the two MSB operand bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_carry <= 1'b0;
    end else if (en) begin
      msb_carry <= total[SEG_W-1] ^ a[SEG_W-1] ^ b[SEG_W-1];
    end
  end
`endif

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract unit, one SEG_W-bit segment per stage with
// the carry registered between stages and valid/ready flow control.
// Define PIPE_ADDER_OVF_EN to add the out_ovf two's-complement overflow port.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG_W = SEG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef PIPE_ADDER_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  if ((WIDTH % SEG_W) != 0 || NSEG < 1) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic                       advance;
  logic [WIDTH-1:0]           b_eff;
  logic                       c_eff;
  seg_ctl_t [NSEG-1:0]        ctl;
  logic [NSEG-1:0][SEG_W-1:0] seg_sum;
`ifdef PIPE_ADDER_OVF_EN
  logic [NSEG-1:0]            msb_c;
`endif

  // Whole pipeline moves when the output slot is empty or being taken.
  always_comb begin
    advance  = !ctl[NSEG-1].valid || out_ready;
    in_ready = advance;
  end

  // Subtract is A + ~B + ~borrow, so only B and the carry-in change.
  always_comb begin
    b_eff = in_sub ? ~in_b : in_b;
    c_eff = in_sub ? ~in_cin : in_cin;
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [SEG_W-1:0] a_k;
    logic [SEG_W-1:0] b_k;
    logic             c_k;
    logic             v_k;

    if (k == 0) begin : g_first
      // Stage 0 takes its segment and carry straight from the inputs.
      always_comb begin
        a_k = in_a[SEG_W-1:0];
        b_k = b_eff[SEG_W-1:0];
        c_k = c_eff;
        v_k = in_valid;
      end
    end else begin : g_skew
      logic [SEG_W-1:0] a_dly [k];
      logic [SEG_W-1:0] b_dly [k];

      // Skew chain: operand segment k waits k cycles to meet its incoming carry.
      // NOTE: these delay arrays are reset because the outputs must read zero after reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < k; j++) begin
            a_dly[j] <= '0;
            b_dly[j] <= '0;
          end
        end else if (advance) begin
          a_dly[0] <= in_a[k*SEG_W +: SEG_W];
          b_dly[0] <= b_eff[k*SEG_W +: SEG_W];
          for (int j = 1; j < k; j++) begin
            a_dly[j] <= a_dly[j-1];
            b_dly[j] <= b_dly[j-1];
          end
        end
      end

      // Later stages take the delayed operands and the previous stage's carry.
      always_comb begin
        a_k = a_dly[k-1];
        b_k = b_dly[k-1];
        c_k = ctl[k-1].carry;
        v_k = ctl[k-1].valid;
      end
    end

    adder_seg #(.SEG_W(SEG_W)) u_seg (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (advance),
      .valid    (v_k),
      .a        (a_k),
      .b        (b_k),
      .cin      (c_k),
      .ctl      (ctl[k]),
`ifdef PIPE_ADDER_OVF_EN
      .msb_carry(msb_c[k]),
`endif
      .sum      (seg_sum[k])
    );
  end

  for (genvar k = 0; k < NSEG - 1; k++) begin : g_deskew
    localparam int D = NSEG - 1 - k;
    logic [SEG_W-1:0] r_dly [D];

    // De-skew chain: result segment k waits until the top segment is done.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < D; j++) begin
          r_dly[j] <= '0;
        end
      end else if (advance) begin
        r_dly[0] <= seg_sum[k];
        for (int j = 1; j < D; j++) begin
          r_dly[j] <= r_dly[j-1];
        end
      end
    end

    assign out_sum[k*SEG_W +: SEG_W] = r_dly[D-1];
  end

  assign out_sum[(NSEG-1)*SEG_W +: SEG_W] = seg_sum[NSEG-1];

  // Output slot is the last stage register.
  always_comb begin
    out_valid = ctl[NSEG-1].valid;
    out_cout  = ctl[NSEG-1].carry;
`ifdef PIPE_ADDER_OVF_EN
    out_ovf   = msb_c[NSEG-1] ^ ctl[NSEG-1].carry;
`endif
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, SEG_W=4): directed literal cases,
// a back-to-back stream with a stall, a mid-flight reset and randomized traffic,
// all scored against a plain-arithmetic model with ordering and latency tracking.
module tb_pipe_adder;

  localparam int WIDTH = 16;
  localparam int SEG_W = 4;
  localparam int NSEG  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef PIPE_ADDER_OVF_EN
  logic             out_ovf;
`endif

  pipe_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
`ifdef PIPE_ADDER_OVF_EN
    .out_ovf  (out_ovf),
`endif
    .out_cout (out_cout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired or no expectation at %0t", name, $time);
  endtask

  // Behavioural model: plain WIDTH+1-bit arithmetic and the sign rule for overflow.
  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               acc_cyc;
    int               acc_stall;
  } exp_t;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    exp_t             e;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   t;
    bb = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sub ? ~cin : cin)};
    e.sum  = t[WIDTH-1:0];
    e.cout = t[WIDTH];
    e.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    e.acc_cyc   = 0;
    e.acc_stall = 0;
    return e;
  endfunction

  exp_t q[$];
  bit   front_seen = 0;
  int   cyc    = 0;
  int   stalls = 0;
  int   exits  = 0;

  always @(posedge clk) cyc++;

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      front_seen = 0;
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (q.size() == 0) begin
          fail_now("unexpected_out");
        end else begin
          if (!front_seen) begin
            check("latency", cyc, q[0].acc_cyc + NSEG + stalls - q[0].acc_stall);
            front_seen = 1;
          end
          check("out_sum", out_sum, q[0].sum);
          check("out_cout", out_cout, q[0].cout);
`ifdef PIPE_ADDER_OVF_EN
          check("out_ovf", out_ovf, q[0].ovf);
`endif
          if (out_ready) begin
            void'(q.pop_front());
            front_seen = 0;
            exits++;
          end
        end
      end
      if (!in_ready) stalls++;
      if (in_valid && in_ready) begin
        e = model(in_a, in_b, in_cin, in_sub);
        e.acc_cyc   = cyc;
        e.acc_stall = stalls;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while ((out_valid || q.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (out_valid || q.size() != 0) fail_now("wait_idle");
  endtask

  // Single transaction into an idle pipe, checked against hand-computed literals.
  task automatic directed(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub, input logic [WIDTH-1:0] es,
                          input logic ec, input logic eo, input bit chk_ovf);
    int ca;
    int guard;
    out_ready = 1'b1;
    wait_idle();
    @(posedge clk); #1;
    drive(1'b1, a, b, cin, sub);
    @(negedge clk);
    ca = cyc;
    check({name, "_accept"}, in_ready, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!out_valid && guard < 20);
    if (!out_valid) begin
      fail_now({name, "_timeout"});
    end else begin
      check({name, "_lat"}, cyc - ca, NSEG);
      check({name, "_sum"}, out_sum, es);
      check({name, "_cout"}, out_cout, ec);
`ifdef PIPE_ADDER_OVF_EN
      if (chk_ovf) check({name, "_ovf"}, out_ovf, eo);
`else
      if (chk_ovf && eo) $display("note: overflow port not built, %s ovf skipped", name);
`endif
    end
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'hFFFF;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'h0000;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    int i;
    int guard;
    int exits0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 16'h0000);
    check("rst_out_cout", out_cout, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
`ifdef PIPE_ADDER_OVF_EN
    check("rst_out_ovf", out_ovf, 1'b0);
`endif
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Directed literal cases.
    directed("add_1_3",    16'h0001, 16'h0003, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b1);
    directed("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("sub_5_7",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    directed("sub_7_5_b",  16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
    directed("add_cin",    16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    directed("ovf_add",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    directed("ovf_sub",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    directed("no_ovf",     16'h0004, 16'h0004, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b1);

    // Back-to-back stream with out_ready low for three cycles mid-stream.
    wait_idle();
    exits0 = exits;
    i = 0;
    guard = 0;
    while (i < 8 && guard < 200) begin
      @(posedge clk); #1;
      drive(1'b1, WIDTH'(i), WIDTH'(16'h0100 * i), 1'b0, 1'b0);
      out_ready = !(guard inside {5, 6, 7});
      @(negedge clk);
      if (guard inside {5, 6, 7}) check("stream_stall_in_ready", in_ready, 1'b0);
      if (in_ready) i++;
      guard++;
    end
    if (i < 8) fail_now("stream_send");
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    wait_idle();
    check("stream_exits", exits - exits0, 8);

    // Mid-flight reset: three results in flight, the first parked at the output.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      drive(1'b1, WIDTH'(16'h0011 * (k + 1)), 16'h0101, 1'b0, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!out_valid && guard < 20);
    check("pre_reset_valid", out_valid, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_sum", out_sum, 16'h0000);
    check("mid_rst_cout", out_cout, 1'b0);
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    directed("post_reset", 16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b1);

    // Randomized traffic with random backpressure and corner operands.
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      drive($urandom_range(0, 9) < 7, pick(), pick(), 1'($urandom), 1'($urandom));
      out_ready = $urandom_range(0, 9) < 7;
    end
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    wait_idle();
    check("final_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
